// File: rtl/decoder_pkg.sv
// Shared types, mode constants and the one-hot helper for decoder_nto2n_seq.
package decoder_pkg;

   // Upper bound on the select width; onehot() works on vectors this wide
   localparam int MAX_SEL_W = 8;
   localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_e;

   // One-hot encode 'code' for a decoder of select width sel_w.
   // msb_first = 1 maps code 0 to the top output bit.
   function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] code,
                                                   input logic                 msb_first,
                                                   input int                   sel_w);
      int idx;
      idx = msb_first ? ((1 << sel_w) - 1 - int'(code)) : int'(code);
      return {{(MAX_OUT_W-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter for the scan mode: counts cycles spent on one scan position
// and raises a terminal-count pulse when the programmed dwell is reached.
module dwell_counter
   import decoder_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               en,
   input  logic [DWELL_W-1:0] dwell,
   output logic               tc
);

   logic [DWELL_W-1:0] count_q;
   logic [DWELL_W-1:0] count_d;
   logic               at_dwell;

   // >= rather than == so that lowering dwell below the running count ends
   // the position at the next compare instead of running through a full wrap
   assign at_dwell = (count_q >= dwell);
   assign tc       = en && !clr && at_dwell;

   // Next count: clear wins, otherwise count up and wrap at the dwell value
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = at_dwell ? '0 : count_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with active-low enable.
// DIRECT mode decodes codes accepted over a valid/ready handshake; SCAN mode
// walks the one-hot output through every position with a programmable dwell.
// Build option: define DECODER_BLANK_EN to insert one blank cycle (out = 0)
// at every scan position advance.
module decoder_nto2n_seq
   import decoder_pkg::*;
#(
   parameter int SEL_W     = 3,
   parameter int DWELL_W   = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_n,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel_in,
   input  logic                  sel_vld,
   output logic                  sel_rdy,
   input  logic [DWELL_W-1:0]    dwell,
   output logic [2**SEL_W-1:0]   out,
   output logic                  out_vld,
   output logic [SEL_W-1:0]      cur_sel
);

   localparam int OUT_W = 2 ** SEL_W;

   state_e             state_q, state_d;
   logic [OUT_W-1:0]   out_q, out_d;
   logic               out_vld_q, out_vld_d;
   logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
   logic               blank_q, blank_d;
   logic               cnt_clr;
   logic               cnt_en;
   logic               cnt_tc;

   function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] code);
      return OUT_W'(onehot(MAX_SEL_W'(code), MSB_FIRST != 0, SEL_W));
   endfunction

   // Ready only while enabled in DIRECT mode, and never while in reset
   assign sel_rdy = rst_n && !en_n && (mode == MODE_DIRECT);

   // Counter restarts when SCAN is entered and runs only on active scan cycles
   assign cnt_clr = !en_n && (mode == MODE_SCAN) && (state_q != SCAN);
   assign cnt_en  = !en_n && (mode == MODE_SCAN) && (state_q == SCAN) && !blank_q;

   dwell_counter #(
      .DWELL_W (DWELL_W)
   ) u_dwell_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .dwell (dwell),
      .tc    (cnt_tc)
   );

   // Next-state and output decode; priority is enable, then mode, then handshake
   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      out_vld_d = out_vld_q;
      cur_sel_d = cur_sel_q;
      blank_d   = 1'b0;

      if (en_n) begin
         // Disabled: blank the output, keep cur_sel for observability
         state_d   = IDLE;
         out_d     = '0;
         out_vld_d = 1'b0;
      end else if (mode == MODE_SCAN) begin
         state_d = SCAN;
         if (state_q != SCAN) begin
            // Fresh entry always starts the walk at code 0
            cur_sel_d = '0;
            out_d     = dec('0);
            out_vld_d = 1'b1;
         end else if (blank_q) begin
            // End of the blanking gap: show the already-advanced position
            out_d     = dec(cur_sel_q);
            out_vld_d = 1'b1;
         end else if (cnt_tc) begin
            cur_sel_d = cur_sel_q + 1'b1;
`ifdef DECODER_BLANK_EN
            out_d     = '0;
            out_vld_d = 1'b0;
            blank_d   = 1'b1;
`else
            out_d     = dec(cur_sel_q + 1'b1);
            out_vld_d = 1'b1;
`endif
         end
      end else begin
         state_d = DIRECT;
         if (sel_vld) begin
            out_d     = dec(sel_in);
            cur_sel_d = sel_in;
            out_vld_d = 1'b1;
         end else if (state_q == SCAN) begin
            // Leaving SCAN keeps the last scanned code on the output
            out_d     = dec(cur_sel_q);
            out_vld_d = 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         out_q     <= '0;
         out_vld_q <= 1'b0;
         cur_sel_q <= '0;
         blank_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
         cur_sel_q <= cur_sel_d;
         blank_q   <= blank_d;
      end
   end

   assign out     = out_q;
   assign out_vld = out_vld_q;
   assign cur_sel = cur_sel_q;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Self-checking bench for decoder_nto2n_seq: an MSB-first and an LSB-first
// instance share all inputs; DIRECT mode is driven from a vector table, scan
// and mode/reset corner cases from hand-written sequences.
module tb_decoder_nto2n_seq;

   logic       clk;
   logic       rst_n;
   logic       en_n;
   logic       mode;
   logic [2:0] sel_in;
   logic       sel_vld;
   logic [7:0] dwell;

   logic       sel_rdy,   sel_rdy_l;
   logic [7:0] out,       out_l;
   logic       out_vld,   out_vld_l;
   logic [2:0] cur_sel,   cur_sel_l;

   int n_vec = 0;
   int n_err = 0;

   decoder_nto2n_seq #(.SEL_W(3), .DWELL_W(8), .MSB_FIRST(1)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_n    (en_n),
      .mode    (mode),
      .sel_in  (sel_in),
      .sel_vld (sel_vld),
      .sel_rdy (sel_rdy),
      .dwell   (dwell),
      .out     (out),
      .out_vld (out_vld),
      .cur_sel (cur_sel)
   );

   decoder_nto2n_seq #(.SEL_W(3), .DWELL_W(8), .MSB_FIRST(0)) u_dut_lsb (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_n    (en_n),
      .mode    (mode),
      .sel_in  (sel_in),
      .sel_vld (sel_vld),
      .sel_rdy (sel_rdy_l),
      .dwell   (dwell),
      .out     (out_l),
      .out_vld (out_vld_l),
      .cur_sel (cur_sel_l)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       en_n;
      logic       mode;
      logic       sel_vld;
      logic [2:0] sel_in;
      logic [7:0] exp_out;   // MSB-first expectation
      logic       exp_vld;
      logic [2:0] exp_cur;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare both instances; the LSB-first output is the bit-reverse of the MSB-first one
   task automatic check(input string name, input logic [7:0] e_out, input logic e_vld,
                        input logic [2:0] e_cur);
      logic [7:0] e_lsb;
      for (int i = 0; i < 8; i++) e_lsb[i] = e_out[7-i];
      n_vec++;
      if (out !== e_out || out_vld !== e_vld || cur_sel !== e_cur ||
          out_l !== e_lsb || out_vld_l !== e_vld || cur_sel_l !== e_cur) begin
         n_err++;
         $display("FAIL %s: got out=%b vld=%b cur=%0d lsb_out=%b lsb_vld=%b lsb_cur=%0d, want out=%b vld=%b cur=%0d lsb_out=%b",
                  name, out, out_vld, cur_sel, out_l, out_vld_l, cur_sel_l, e_out, e_vld, e_cur, e_lsb);
      end else begin
         $display("[%0t] %s out=%b vld=%b cur=%0d", $time, name, out, out_vld, cur_sel);
      end
   endtask

   task automatic check_rdy(input string name, input logic e_rdy);
      n_vec++;
      if (sel_rdy !== e_rdy || sel_rdy_l !== e_rdy) begin
         n_err++;
         $display("FAIL %s: got sel_rdy=%b/%b, want %b", name, sel_rdy, sel_rdy_l, e_rdy);
      end else begin
         $display("[%0t] %s sel_rdy=%b", $time, name, sel_rdy);
      end
   endtask

   // Scan reference: position and active flag t edges after scan entry (t = 0 is the entry edge)
   function automatic void scan_exp(input int t, input int d, output int pos, output bit act);
`ifdef DECODER_BLANK_EN
      int k;
      if (t <= d) begin
         pos = 0;
         act = 1'b1;
      end else begin
         k   = t - (d + 1);
         pos = (1 + k / (d + 2)) % 8;
         act = (k % (d + 2)) != 0;
      end
`else
      pos = (t / (d + 1)) % 8;
      act = 1'b1;
`endif
   endfunction

   task automatic check_scan(input string name, input int t, input int d);
      int pos;
      bit act;
      scan_exp(t, d, pos, act);
      check(name, act ? (8'h80 >> pos) : 8'h00, act, 3'(pos));
   endtask

   // Hold the current inputs for n edges, checking each against the scan reference
   task automatic run_scan(input string name, input int n, input int d);
      for (int t = 0; t < n; t++) begin
         tick();
         check_scan(name, t, d);
      end
   endtask

   initial begin
      int pos;
      bit act;
      bit found;

      //               en_n  mode  vld   sel   exp_out       vld   cur
      vecs[0] = '{1'b0, 1'b0, 1'b1, 3'd0, 8'b1000_0000, 1'b1, 3'd0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 3'd5, 8'b0000_0100, 1'b1, 3'd5};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 3'd7, 8'b0000_0100, 1'b1, 3'd5};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 3'd1, 8'b0100_0000, 1'b1, 3'd1};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 3'd2, 8'b0010_0000, 1'b1, 3'd2};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 3'd3, 8'b0001_0000, 1'b1, 3'd3};
      vecs[6] = '{1'b1, 1'b0, 1'b1, 3'd6, 8'b0000_0000, 1'b0, 3'd3};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 3'd4, 8'b0000_0000, 1'b0, 3'd3};
      vecs[8] = '{1'b0, 1'b0, 1'b1, 3'd7, 8'b0000_0001, 1'b1, 3'd7};
      vecs[9] = '{1'b1, 1'b0, 1'b0, 3'd7, 8'b0000_0000, 1'b0, 3'd7};

      // Reset with the block otherwise enabled in DIRECT: sel_rdy must stay low
      rst_n   = 1'b0;
      en_n    = 1'b0;
      mode    = 1'b0;
      sel_vld = 1'b1;
      sel_in  = 3'd5;
      dwell   = 8'd0;
      #3;
      check("reset", 8'h00, 1'b0, 3'd0);
      check_rdy("reset_rdy", 1'b0);
      tick();
      tick();
      check("reset_held", 8'h00, 1'b0, 3'd0);
      rst_n = 1'b1;

      // DIRECT mode table
      for (int i = 0; i < 10; i++) begin
         en_n    = vecs[i].en_n;
         mode    = vecs[i].mode;
         sel_vld = vecs[i].sel_vld;
         sel_in  = vecs[i].sel_in;
         #1;
         check_rdy($sformatf("vec%0d_rdy", i), !vecs[i].en_n && !vecs[i].mode);
         tick();
         check($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_vld, vecs[i].exp_cur);
      end

      // SCAN, dwell = 2: full walk plus wrap back to 0
      en_n    = 1'b0;
      mode    = 1'b1;
      sel_vld = 1'b0;
      dwell   = 8'd2;
      run_scan("scan_d2", 27, 2);

      // Disable holds cur_sel, then dwell = 0 advances every cycle
      en_n = 1'b1;
      tick();
      scan_exp(26, 2, pos, act);
      check("scan_disable", 8'h00, 1'b0, 3'(pos));
      en_n  = 1'b0;
      dwell = 8'd0;
      run_scan("scan_d0", 10, 0);

      // Disable mid-scan at code 4, then re-enable restarts at code 0
      en_n = 1'b1;
      tick();
      en_n  = 1'b0;
      dwell = 8'd2;
      found = 1'b0;
      for (int t = 0; t < 40 && !found; t++) begin
         tick();
         check_scan("scan_to4", t, 2);
         scan_exp(t, 2, pos, act);
         found = (pos == 4) && act;
      end
      if (!found) begin
         n_vec++;
         n_err++;
         $display("FAIL scan_to4_timeout: got no active code 4 within 40 cycles, want code 4");
      end
      en_n = 1'b1;
      tick();
      check("dis_at4", 8'h00, 1'b0, 3'd4);
      en_n = 1'b0;
      run_scan("restart", 4, 2);

      // DIRECT accept, then DIRECT->SCAN with a coincident sel_vld that must be ignored
      mode    = 1'b0;
      sel_vld = 1'b1;
      sel_in  = 3'd6;
      tick();
      check("direct6", 8'b0000_0010, 1'b1, 3'd6);
      mode   = 1'b1;
      sel_in = 3'd3;
      dwell  = 8'd1;
      #1;
      check_rdy("d2s_rdy", 1'b0);
      run_scan("dir2scan", 5, 1);

      // SCAN->DIRECT with no accept holds the last scanned code as valid
      mode    = 1'b0;
      sel_vld = 1'b0;
      scan_exp(4, 1, pos, act);
      tick();
      check("s2d_hold", 8'h80 >> pos, 1'b1, 3'(pos));
      tick();
      check("s2d_hold2", 8'h80 >> pos, 1'b1, 3'(pos));

      // Asynchronous reset mid-scan clears at once; scan restarts from IDLE afterwards
      mode  = 1'b1;
      dwell = 8'd3;
      run_scan("rescan", 6, 3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst", 8'h00, 1'b0, 3'd0);
      check_rdy("async_rst_rdy", 1'b0);
      tick();
      check("rst_over_edge", 8'h00, 1'b0, 3'd0);
      rst_n = 1'b1;
      run_scan("post_rst", 3, 3);

      // dwell = 1: two active cycles per position (plus one blank cycle when blanking is built in)
      en_n = 1'b1;
      tick();
      en_n  = 1'b0;
      dwell = 8'd1;
      run_scan("scan_d1", 12, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
